// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : two-port arbiter in front of a single-port data SRAM
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            h0_req_i,
  output logic            h0_gnt_o,
  input  logic            h0_we_i,
  input  logic [AW-1:0]   h0_addr_i,
  input  logic [DW-1:0]   h0_wdata_i,
  input  logic [DW-1:0]   h0_wmask_i,
  output logic            h0_rvalid_o,
  output logic [DW-1:0]   h0_rdata_o,
  input  logic            h1_req_i,
  output logic            h1_gnt_o,
  input  logic            h1_we_i,
  input  logic [AW-1:0]   h1_addr_i,
  input  logic [DW-1:0]   h1_wdata_i,
  input  logic [DW-1:0]   h1_wmask_i,
  output logic            h1_rvalid_o,
  output logic [DW-1:0]   h1_rdata_o,
  output logic            mem_en_o,
  output logic [DW/8-1:0] mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic [DW-1:0]   mem_rdata_i
);

  localparam int NB = DW / 8;

  logic          r_ptr;
  logic          r_rsp_valid;
  logic          r_rsp_port;

  logic          w_pick1;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_any;
  logic          w_we;
  logic [DW-1:0] w_mask;

  // Port 1 wins when it is alone, or when contended and the pointer favours it.
  assign w_pick1 = h1_req_i && (!h0_req_i || ((FIXED_PRIO == 0) && r_ptr));
  assign w_gnt1  = reset && w_pick1;
  assign w_gnt0  = reset && h0_req_i && !w_pick1;
  assign w_any   = w_gnt0 || w_gnt1;

  assign h0_gnt_o = w_gnt0;
  assign h1_gnt_o = w_gnt1;

  assign w_we        = w_gnt1 ? h1_we_i    : h0_we_i;
  assign w_mask      = w_gnt1 ? h1_wmask_i : h0_wmask_i;
  assign mem_en_o    = w_any;
  assign mem_addr_o  = w_gnt1 ? h1_addr_i  : h0_addr_i;
  assign mem_wdata_o = w_gnt1 ? h1_wdata_i : h0_wdata_i;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign mem_we_o[i] = w_any && w_we && (|w_mask[8*i +: 8]);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ptr       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_port  <= 1'b0;
    end else begin
      if (w_any) begin
        r_ptr <= w_gnt0;
      end
      r_rsp_valid <= w_any && !w_we;
      if (w_any && !w_we) begin
        r_rsp_port <= w_gnt1;
      end
    end
  end

  // Gated by reset so a response pending at reset assertion never escapes.
  assign h0_rvalid_o = reset && r_rsp_valid && !r_rsp_port;
  assign h1_rvalid_o = reset && r_rsp_valid &&  r_rsp_port;
  assign h0_rdata_o  = h0_rvalid_o ? mem_rdata_i : '0;
  assign h1_rdata_o  = h1_rvalid_o ? mem_rdata_i : '0;

endmodule

`default_nettype wire
